// File: rtl/fetch_group_pc.sv
// Fetch-group PC generator: presents ISSUE_W consecutive instruction numbers per cycle
// and advances by the number the issue stage accepted, with redirect, end detection and stall count.
module fetch_group_pc #(
  parameter int unsigned PC_W    = 5,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned LAST_PC = 31,
  parameter int unsigned STALL_W = 8,
  localparam int unsigned CNT_W  = $clog2(ISSUE_W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic [CNT_W-1:0]   accept_cnt,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_valid,
  output logic [ISSUE_W-1:0] group_mask,
  output logic               partial,
  output logic               done,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam int unsigned      X_W    = PC_W + 1;
  localparam logic [X_W-1:0]   LAST_X = X_W'(LAST_PC);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [PC_W-1:0]    pc_n;
  logic               partial_n;
  logic [STALL_W-1:0] stall_n;
  logic [CNT_W-1:0]   pop;
  logic [CNT_W-1:0]   eff;
  logic [X_W-1:0]     nxt;
  logic               redirect_oob;

  assign fetch_valid = (state == RUN);
  assign done        = (state == DONE);

  // Lane validity uses a wide compare so lanes past LAST_PC never wrap back into range.
  always_comb begin
    group_mask = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      group_mask[i] = fetch_valid && ((32'(pc) + 32'(i)) <= 32'(LAST_PC));
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      pop = pop + CNT_W'(group_mask[i]);
    end
  end

  // Clamp over-reported accepts to the number of valid lanes.
  assign eff          = (accept_cnt < pop) ? accept_cnt : pop;
  assign nxt          = {1'b0, pc} + X_W'(eff);
  assign redirect_oob = ({1'b0, redirect_pc} > LAST_X);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= '0;
      partial      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      partial      <= partial_n;
      stall_cycles <= stall_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    partial_n = partial;
    stall_n   = stall_cycles;
    if (flush) begin
      state_n   = active ? RUN : IDLE;
      pc_n      = '0;
      partial_n = 1'b0;
      stall_n   = '0;
    end else if (!active) begin
      state_n   = IDLE;
      pc_n      = '0;
      partial_n = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = RUN;
        RUN: begin
          if (redirect_valid) begin
            pc_n      = redirect_pc;
            partial_n = 1'b0;
            state_n   = redirect_oob ? DONE : RUN;
          end else if (eff == '0) begin
            if (stall_cycles != '1) stall_n = stall_cycles + STALL_W'(1);
          end else begin
            partial_n = (32'(eff) < ISSUE_W) && (nxt <= LAST_X);
            if (nxt > LAST_X) state_n = DONE;
            else              pc_n    = nxt[PC_W-1:0];
          end
        end
        DONE: begin
          if (redirect_valid) begin
            pc_n      = redirect_pc;
            partial_n = 1'b0;
            state_n   = redirect_oob ? DONE : RUN;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_group_pc.md
Name: fetch_group_pc

Overview:
Parametrised fetch-group PC generator for the multi-issue pipeline; successor to the single-PC fetch counter. Each cycle it presents a group of ISSUE_W consecutive instruction numbers to the instruction buffer. The PC advances by the number of instructions the issue stage actually accepted, which replaces the old decrement-on-hazard scheme. It also supports branch redirect, program-end detection and a stall performance counter.

Parameters:
PC_W, 5, width of instruction number / PC
ISSUE_W, 2, instructions per fetch group (1..8)
LAST_PC, 31, highest valid instruction number; must be <= 2^PC_W-1
STALL_W, 8, width of stall-cycle counter
(localparam CNT_W = clog2(ISSUE_W+1))

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
active  in  1  core enable; low forces IDLE with pc=0
flush  in  1  synchronous restart of fetch at pc 0
redirect_valid  in  1  branch/jump redirect request
redirect_pc  in  PC_W  redirect target
accept_cnt  in  CNT_W  instructions of current group consumed this cycle (0..ISSUE_W)
pc  out  PC_W  first instruction number of current group
fetch_valid  out  1  group valid (state RUN)
group_mask  out  ISSUE_W  lane i valid iff fetch_valid and pc+i <= LAST_PC (full-width compare, no wrap)
partial  out  1  previous group was only partly accepted
done  out  1  program exhausted (state DONE)
stall_cycles  out  STALL_W  saturating count of zero-accept RUN cycles

Behaviour:
- Reset (reset=0, async): state IDLE, pc=0, partial=0, stall_cycles=0. Hence fetch_valid=0, group_mask=0, done=0.
- States: IDLE, RUN, DONE. fetch_valid=(state==RUN). done=(state==DONE). Both are decoded from registered state.
- Per-clock priority: flush > !active > redirect_valid > accept_cnt.
- flush: pc<=0, partial<=0, stall_cycles<=0. Next state is RUN if active=1, else IDLE.
- active=0 (no flush): state<=IDLE, pc<=0, partial<=0. stall_cycles is held.
- IDLE & active=1: state<=RUN, pc stays 0. The first fetch_valid appears one cycle after active rises.
- RUN & redirect_valid: pc<=redirect_pc, partial<=0, accept_cnt ignored. If redirect_pc > LAST_PC, state<=DONE with pc<=redirect_pc; otherwise stay RUN.
- DONE & redirect_valid: same target check. A legal target returns the block to RUN.
- RUN, no redirect:
  - eff = min(accept_cnt, popcount(group_mask)). Over-reporting is clamped.
  - nxt = pc + eff, computed in PC_W+1 bits.
  - If nxt > LAST_PC: state<=DONE, pc held (no wrap).
  - Otherwise pc<=nxt[PC_W-1:0].
  - partial<=(eff!=0 && eff<ISSUE_W && nxt<=LAST_PC).
  - eff==0: pc held, partial held, stall_cycles+=1, saturating at all-ones.
- DONE, no redirect: everything held. accept_cnt is ignored.
- Reset asserted mid-operation wins immediately (async). Release is synchronous to the next clk edge, with normal IDLE->RUN entry.
- No combinational path from any input to any output. All outputs derive from registers.

Test Plan:
- Reset/start (ISSUE_W=2, LAST_PC=31): assert reset=0 → all outputs 0. Release, set active=1 → next cycle fetch_valid=1, pc=0, group_mask=2'b11.
- Full and partial accept: accept_cnt=2,2,1,0,2 → pc sequence 0,2,4,5,5,7. partial=1 only in the cycle pc=5 first appears, then stays 1 through the stall cycle (pc=5 held). stall_cycles=1.
- Program end (LAST_PC=9): run with accept_cnt=2 → pc 0,2,4,6,8. At pc=8, group_mask=2'b11; accept 2 gives nxt=10 → done=1, fetch_valid=0, pc=8 held. Over-report check: at pc=9, group_mask=2'b01 and accept_cnt=2 is clamped to 1 → nxt=10 → done=1, pc=9 held.
- Redirect: at pc=6, redirect_valid=1, redirect_pc=20, accept_cnt=2 → next pc=20, partial=0. While in DONE, redirect to 3 → RUN, pc=3. Redirect to 40 with PC_W=6, LAST_PC=31 → DONE.
- Priority: assert flush and redirect together at pc=12 → pc=0, stall_cycles=0, RUN. Drop active with redirect_valid=1 → IDLE, pc=0. Apply reset=0 between clock edges → outputs clear at once, without waiting for clk.
- Saturation (STALL_W=4): hold accept_cnt=0 for 20 RUN cycles → stall_cycles=15, pc unchanged.
